pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage 16-bit CPU. Consumes the EX-stage ALU control code
//  and hazard info and produces PC/IF-ID write enables and IF-ID/ID-EX flushes.
//  Sequences HLT drain into a halted state, latches WWD output, and counts retired instructions.
// PARAMETERS
//  WORD_W        16  datapath width (output_port)
//  REG_AW        2   register index width
//  CNT_W         16  retired-instruction counter width
//  DRAIN_CYCLES  3   cycles after HLT in EX until all older instrs retire (EX->MEM->WB)
// PORTS
//  clk            in   1        clock; all state updates on rising edge
//  reset          in   1        asynchronous, active-high
//  id_valid       in   1        ID holds a real instruction
//  id_rs, id_rt   in   REG_AW   ID source register indices
//  id_use_rs/rt   in   1        ID instruction actually reads rs / rt
//  ex_valid       in   1        EX holds a real instruction
//  ex_mem_read    in   1        EX instruction is a load (LWD)
//  ex_rd          in   REG_AW   EX destination index
//  ex_alu_ctrl    in   4        ALU control code of EX instr (0xD=WWD, 0xF=HLT)
//  ex_redirect    in   1        EX resolved a taken branch/jump (PC gets target)
//  ex_operand_a   in   WORD_W   EX forwarded rs value (WWD payload)
//  wb_valid       in   1        an instruction retires this cycle
//  pc_write       out  1        PC register enable
//  ifid_write     out  1        IF/ID register enable
//  ifid_flush     out  1        IF/ID loads a bubble
//  idex_flush     out  1        ID/EX loads a bubble
//  halted         out  1        registered; CPU stopped
//  output_port    out  WORD_W   registered; last WWD value
//  num_inst       out  CNT_W    registered; retired-instruction count
// BEHAVIOUR
//  Reset (async, held): state=RUN, drain_cnt=0, halted=0, output_port=0, num_inst=0;
//   comb outputs forced to pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
//  FSM: RUN -> DRAIN on ex_valid & ex_alu_ctrl==HLT (drain_cnt<=DRAIN_CYCLES-1).
//   DRAIN: drain_cnt decrements each cycle; at drain_cnt==0 -> HALTED (halted=1 next edge).
//   HALTED: absorbing until reset.
//  Control outputs (combinational, RUN only), priority high->low:
//   1 HLT in EX: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1 (redirect ignored).
//   2 redirect (ex_valid&ex_redirect): pc_write=1, ifid_flush=1, idex_flush=1; load-use ignored.
//   3 load-use: ex_valid&ex_mem_read&id_valid&((id_use_rs&id_rs==ex_rd)|(id_use_rt&id_rt==ex_rd))
//     -> pc_write=0, ifid_write=0, idex_flush=1 (one bubble; re-evaluated next cycle).
//   4 else pc_write=1, ifid_write=1, flushes=0.
//  DRAIN/HALTED: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1 regardless of inputs.
//  WWD: in RUN, ex_valid&ex_alu_ctrl==WWD -> output_port<=ex_operand_a at that edge (1-cycle
//   latency). WWD is never in EX during DRAIN (flushed); ex_valid=0 instrs never update it.
//  num_inst: +1 on every edge with wb_valid in RUN or DRAIN; frozen in HALTED; wraps 2^CNT_W-1->0.
//  DRAIN_CYCLES==1: HLT edge goes directly RUN->DRAIN with cnt 0, HALTED the following edge.
//  Reset mid-DRAIN/HALTED: immediately RUN, counters cleared, halted deasserts asynchronously.
// STRUCTURE
//  cpu_pkg: ALU control codes (ALU_ADD..ALU_SHR, ALU_LHI=4'h8, ALU_WWD=4'hD, ALU_HLT=4'hF)
//   shared with the ALU control decoder; ctrl_state_t enum {RUN, DRAIN, HALTED}.
//  One sub-module: load_use_detect (pure combinational compare -> stall bit).
//  Top holds FSM, drain counter, output_port and num_inst registers, output priority mux.
// TESTING
//  1 ex_mem_read=1, ex_rd=2, id_rs=2, id_use_rs=1, all valid -> 1 cycle pc_write=0,
//    ifid_write=0, idex_flush=1; next cycle (ex_mem_read=0) all normal.
//  2 load-use + ex_redirect same cycle -> pc_write=1, ifid_flush=1, idex_flush=1.
//  3 ex_alu_ctrl=0xD, ex_operand_a=16'hBEEF, ex_valid=1 -> output_port==16'hBEEF next edge;
//    same with ex_valid=0 -> unchanged.
//  4 HLT in EX at edge N, wb_valid=1 for 3 cycles -> halted=1 after edge N+3, num_inst +3,
//    flush/freeze asserted from HLT cycle on; further wb_valid does not count.
//  5 num_inst preloaded to 16'hFFFF by retirement, one more wb_valid -> 16'h0000.
//  6 assert reset during DRAIN between edges -> halted=0, num_inst=0, output_port=0,
//    pc_write=1 immediately; after release runs normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: ALU control codes,
// the pipeline sequencer state encoding and the bundle of hazard-control
// enables that the sequencer drives into the PC and pipeline registers.
package cpu_pkg;

   // ALU control codes, shared with the ALU control decoder
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_ORR = 4'h3;
   localparam logic [3:0] ALU_NOT = 4'h4;
   localparam logic [3:0] ALU_TCP = 4'h5;
   localparam logic [3:0] ALU_SHL = 4'h6;
   localparam logic [3:0] ALU_SHR = 4'h7;
   localparam logic [3:0] ALU_LHI = 4'h8;
   localparam logic [3:0] ALU_WWD = 4'hD;
   localparam logic [3:0] ALU_HLT = 4'hF;

   // Sequencer states: normal issue, draining older instructions after HLT,
   // and stopped
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } ctrl_state_t;

   // Enables and flushes presented to the front of the pipeline
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_flush;
   } ctrl_out_t;

   // Free-running issue: fetch advances, nothing is squashed
   localparam ctrl_out_t CTRL_NORMAL   = '{pc_write: 1'b1, ifid_write: 1'b1,
                                           ifid_flush: 1'b0, idex_flush: 1'b0};
   // Front end frozen and both younger stages squashed (HLT, drain, halted)
   localparam ctrl_out_t CTRL_FREEZE   = '{pc_write: 1'b0, ifid_write: 1'b0,
                                           ifid_flush: 1'b1, idex_flush: 1'b1};
   // PC loads the branch target while the two wrong-path instructions die
   localparam ctrl_out_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1,
                                           ifid_flush: 1'b1, idex_flush: 1'b1};
   // Load-use: hold PC and IF/ID, inject one bubble into EX
   localparam ctrl_out_t CTRL_STALL    = '{pc_write: 1'b0, ifid_write: 1'b0,
                                           ifid_flush: 1'b0, idex_flush: 1'b1};

   // True when a real instruction in EX carries the given ALU code
   function automatic logic ex_is(input logic valid, input logic [3:0] code,
                                  input logic [3:0] match);
      return valid && (code == match);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the instruction in ID needs a register
// that a load currently in EX has not yet produced. Purely combinational.
module load_use_detect
   import cpu_pkg::*;
#(
   parameter int REG_AW = 2
) (
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   output logic              stall
);

   logic rs_hit;
   logic rt_hit;

   // A source only matters if the ID instruction actually reads it
   always_comb begin
      rs_hit = id_use_rs && (id_rs == ex_rd);
      rt_hit = id_use_rt && (id_rt == ex_rd);
      stall  = ex_valid && ex_mem_read && id_valid && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage CPU: resolves HLT/redirect/load-use
// hazards into PC and pipeline-register controls, drains the pipe after HLT
// into a halted state, latches WWD output and counts retired instructions.
module pipeline_ctrl
   import cpu_pkg::*;
#(
   parameter int WORD_W       = 16,
   parameter int REG_AW       = 2,
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [3:0]        ex_alu_ctrl,
   input  logic              ex_redirect,
   input  logic [WORD_W-1:0] ex_operand_a,
   input  logic              wb_valid,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              halted,
   output logic [WORD_W-1:0] output_port,
   output logic [CNT_W-1:0]  num_inst
);

   // Counter only needs to hold DRAIN_CYCLES-1; keep at least one bit so the
   // single-cycle drain case still has a legal vector
   localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(DRAIN_CYCLES - 1);

   ctrl_state_t       state;
   logic [DCNT_W-1:0] drain_cnt;
   logic              hlt_in_ex;
   logic              wwd_in_ex;
   logic              redirect;
   logic              load_use;
   ctrl_out_t         ctrl;

   assign hlt_in_ex = ex_is(ex_valid, ex_alu_ctrl, ALU_HLT);
   assign wwd_in_ex = ex_is(ex_valid, ex_alu_ctrl, ALU_WWD);
   assign redirect  = ex_valid && ex_redirect;

   load_use_detect #(
      .REG_AW (REG_AW)
   ) u_load_use (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .stall       (load_use)
   );

   // HLT sequencing: count down the older instructions still in MEM/WB, then
   // stop for good; only reset brings the sequencer back to RUN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (hlt_in_ex) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_INIT;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - DCNT_W'(1);
               end
            end
            HALTED: begin
               state  <= HALTED;
               halted <= 1'b1;
            end
            default: begin
               state     <= RUN;
               drain_cnt <= '0;
               halted    <= 1'b0;
            end
         endcase
      end
   end

   // WWD output latch; a WWD only reaches EX while running since the drain
   // flushes everything younger than HLT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         output_port <= '0;
      end else if ((state == RUN) && wwd_in_ex) begin
         output_port <= ex_operand_a;
      end
   end

   // Retired-instruction counter; older instructions still retire while
   // draining, nothing retires once halted; wraps naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_inst <= '0;
      end else if (wb_valid && (state != HALTED)) begin
         num_inst <= num_inst + CNT_W'(1);
      end
   end

   // Hazard priority: HLT beats redirect beats load-use; outside RUN the
   // front end stays frozen, and a held reset presents free-running controls
   always_comb begin
      ctrl = CTRL_NORMAL;
      if (reset) begin
         ctrl = CTRL_NORMAL;
      end else if (state != RUN) begin
         ctrl = CTRL_FREEZE;
      end else if (hlt_in_ex) begin
         ctrl = CTRL_FREEZE;
      end else if (redirect) begin
         ctrl = CTRL_REDIRECT;
      end else if (load_use) begin
         ctrl = CTRL_STALL;
      end
   end

   assign pc_write   = ctrl.pc_write;
   assign ifid_write = ctrl.ifid_write;
   assign ifid_flush = ctrl.ifid_flush;
   assign idex_flush = ctrl.idex_flush;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: scenario tasks push expected values into a
// scoreboard when stimulus is driven and pop them against sampled outputs.
module tb_pipeline_ctrl;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [1:0]  id_rs;
   logic [1:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        ex_valid;
   logic        ex_mem_read;
   logic [1:0]  ex_rd;
   logic [3:0]  ex_alu_ctrl;
   logic        ex_redirect;
   logic [15:0] ex_operand_a;
   logic        wb_valid;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_flush;
   logic        halted;
   logic [15:0] output_port;
   logic [15:0] num_inst;

   logic [3:0]  ctrl_bits;
   assign ctrl_bits = {pc_write, ifid_write, ifid_flush, idex_flush};

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] obs[$];
   int          tests_run;
   int          tests_failed;

   pipeline_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .ex_valid     (ex_valid),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .ex_alu_ctrl  (ex_alu_ctrl),
      .ex_redirect  (ex_redirect),
      .ex_operand_a (ex_operand_a),
      .wb_valid     (wb_valid),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .halted       (halted),
      .output_port  (output_port),
      .num_inst     (num_inst)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_idle();
      id_valid     = 1'b0;
      id_rs        = 2'd0;
      id_rt        = 2'd0;
      id_use_rs    = 1'b0;
      id_use_rt    = 1'b0;
      ex_valid     = 1'b0;
      ex_mem_read  = 1'b0;
      ex_rd        = 2'd0;
      ex_alu_ctrl  = 4'h0;
      ex_redirect  = 1'b0;
      ex_operand_a = 16'h0000;
      wb_valid     = 1'b0;
   endtask

   task automatic apply_load_use_rs();
      ex_valid    = 1'b1;
      ex_mem_read = 1'b1;
      ex_rd       = 2'd2;
      id_valid    = 1'b1;
      id_rs       = 2'd2;
      id_use_rs   = 1'b1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic push_exp(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic push_obs(input logic [31:0] v);
      obs.push_back(v);
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [31:0] a;
      apply_idle();
      reset = 1'b1;
      apply_load_use_rs();
      wb_valid = 1'b1;
      repeat (2) tick();
      push_exp("reset_ctrl", 32'h0000000C);   push_obs({28'd0, ctrl_bits});
      push_exp("reset_halted", 32'h0);        push_obs({31'd0, halted});
      push_exp("reset_port", 32'h0);          push_obs({16'd0, output_port});
      push_exp("reset_cnt", 32'h0);           push_obs({16'd0, num_inst});
      apply_idle();
      #1;
      reset = 1'b0;
      tick();
      push_exp("post_reset_ctrl", 32'h0000000C); push_obs({28'd0, ctrl_bits});
      push_exp("post_reset_cnt", 32'h0);         push_obs({16'd0, num_inst});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_load_use();
      exp_t        e;
      logic [31:0] a;
      apply_idle();
      apply_load_use_rs();
      #1;
      push_exp("lu_rs_stall", 32'h1);  push_obs({28'd0, ctrl_bits});
      tick();
      ex_mem_read = 1'b0;
      #1;
      push_exp("lu_release", 32'hC);   push_obs({28'd0, ctrl_bits});
      tick();
      apply_idle();
      ex_valid    = 1'b1;
      ex_mem_read = 1'b1;
      ex_rd       = 2'd3;
      id_valid    = 1'b1;
      id_rs       = 2'd1;
      id_rt       = 2'd3;
      id_use_rt   = 1'b1;
      #1;
      push_exp("lu_rt_stall", 32'h1);  push_obs({28'd0, ctrl_bits});
      id_rt = 2'd0;
      #1;
      push_exp("lu_rt_miss", 32'hC);   push_obs({28'd0, ctrl_bits});
      id_rs = 2'd3;
      #1;
      push_exp("lu_rs_unused", 32'hC); push_obs({28'd0, ctrl_bits});
      id_use_rs = 1'b1;
      id_valid  = 1'b0;
      #1;
      push_exp("lu_id_invalid", 32'hC); push_obs({28'd0, ctrl_bits});
      id_valid = 1'b1;
      ex_valid = 1'b0;
      #1;
      push_exp("lu_ex_invalid", 32'hC); push_obs({28'd0, ctrl_bits});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_redirect();
      exp_t        e;
      logic [31:0] a;
      tick();
      apply_idle();
      apply_load_use_rs();
      ex_redirect = 1'b1;
      #1;
      push_exp("redir_over_lu", 32'h7);
      push_obs({29'd0, pc_write, ifid_flush, idex_flush});
      ex_valid = 1'b0;
      #1;
      push_exp("redir_ex_invalid", 32'hC); push_obs({28'd0, ctrl_bits});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_wwd();
      exp_t        e;
      logic [31:0] a;
      tick();
      apply_idle();
      ex_valid     = 1'b1;
      ex_alu_ctrl  = 4'hD;
      ex_operand_a = 16'hBEEF;
      push_exp("wwd_beef", 32'h0000BEEF);
      tick();
      push_obs({16'd0, output_port});
      ex_valid     = 1'b0;
      ex_operand_a = 16'h1234;
      push_exp("wwd_invalid", 32'h0000BEEF);
      tick();
      push_obs({16'd0, output_port});
      ex_valid     = 1'b1;
      ex_alu_ctrl  = 4'h0;
      ex_operand_a = 16'h5555;
      push_exp("wwd_other_op", 32'h0000BEEF);
      tick();
      push_obs({16'd0, output_port});
      apply_idle();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [31:0] a;
      ex_valid     = 1'b1;
      ex_alu_ctrl  = 4'hD;
      ex_operand_a = 16'hA001;
      push_exp("b2b_first", 32'h0000A001);
      tick();
      push_obs({16'd0, output_port});
      ex_operand_a = 16'hA002;
      push_exp("b2b_second", 32'h0000A002);
      tick();
      push_obs({16'd0, output_port});
      apply_idle();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_halt();
      exp_t        e;
      logic [31:0] a;
      apply_idle();
      pulse_reset();
      ex_valid    = 1'b1;
      ex_alu_ctrl = 4'hF;
      ex_redirect = 1'b1;
      #1;
      push_exp("hlt_cycle_ctrl", 32'h3); push_obs({28'd0, ctrl_bits});
      tick();
      apply_idle();
      wb_valid = 1'b1;
      #1;
      push_exp("drain_ctrl", 32'h3);     push_obs({28'd0, ctrl_bits});
      push_exp("drain_halted0", 32'h0);  push_obs({31'd0, halted});
      for (int i = 1; i <= 2; i++) begin
         tick();
         push_exp("drain_not_halted", 32'h0); push_obs({31'd0, halted});
      end
      tick();
      push_exp("halted_set", 32'h1);      push_obs({31'd0, halted});
      push_exp("drain_retired", 32'h3);   push_obs({16'd0, num_inst});
      ex_valid     = 1'b1;
      ex_alu_ctrl  = 4'hD;
      ex_operand_a = 16'h7777;
      repeat (3) tick();
      push_exp("halted_cnt_frozen", 32'h3); push_obs({16'd0, num_inst});
      push_exp("halted_port_frozen", 32'h0); push_obs({16'd0, output_port});
      push_exp("halted_ctrl", 32'h3);       push_obs({28'd0, ctrl_bits});
      push_exp("halted_stays", 32'h1);      push_obs({31'd0, halted});
      apply_idle();
      reset = 1'b1;
      #1;
      push_exp("halted_async_clear", 32'h0); push_obs({31'd0, halted});
      reset = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_reset_mid_drain();
      exp_t        e;
      logic [31:0] a;
      tick();
      apply_idle();
      ex_valid     = 1'b1;
      ex_alu_ctrl  = 4'hD;
      ex_operand_a = 16'hCAFE;
      tick();
      ex_alu_ctrl  = 4'hF;
      tick();
      apply_idle();
      wb_valid = 1'b1;
      tick();
      push_exp("mid_drain_cnt", 32'h1);    push_obs({16'd0, num_inst});
      push_exp("mid_drain_port", 32'hCAFE); push_obs({16'd0, output_port});
      #2;
      reset = 1'b1;
      #1;
      push_exp("rst_drain_halted", 32'h0); push_obs({31'd0, halted});
      push_exp("rst_drain_cnt", 32'h0);    push_obs({16'd0, num_inst});
      push_exp("rst_drain_port", 32'h0);   push_obs({16'd0, output_port});
      push_exp("rst_drain_pc", 32'h1);     push_obs({31'd0, pc_write});
      wb_valid = 1'b0;
      #1;
      reset = 1'b0;
      tick();
      apply_load_use_rs();
      wb_valid = 1'b1;
      #1;
      push_exp("after_rst_lu", 32'h1);     push_obs({28'd0, ctrl_bits});
      tick();
      apply_idle();
      push_exp("after_rst_cnt", 32'h1);    push_obs({16'd0, num_inst});
      push_exp("after_rst_halted", 32'h0); push_obs({31'd0, halted});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   task automatic test_wrap();
      exp_t        e;
      logic [31:0] a;
      apply_idle();
      pulse_reset();
      wb_valid = 1'b1;
      repeat (65535) tick();
      push_exp("cnt_max", 32'h0000FFFF); push_obs({16'd0, num_inst});
      tick();
      push_exp("cnt_wrap", 32'h0);       push_obs({16'd0, num_inst});
      apply_idle();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests_run++;
         if (obs.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: no output sampled, expected %h", e.tag, e.exp);
         end else begin
            a = obs.pop_front();
            if (a !== e.exp) begin
               tests_failed++;
               $display("[TB] FAIL %s: got %h expected %h", e.tag, a, e.exp);
            end
         end
      end
      obs.delete();
   endtask

   // Scenario sequence
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      apply_idle();
      test_reset();
      test_load_use();
      test_redirect();
      test_wwd();
      test_back_to_back();
      test_halt();
      test_reset_mid_drain();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
